// File: rtl/riscv_pkg.sv
// Shared types for the memory bus arbiter.
// arb_state_e : bus FSM states (IDLE, REQ, RSP).
// arb_owner_e : which port owns the in-flight bus transaction.
// mem_req_t   : field bundle latched into the registered memory request.
package riscv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWNER_IF = 1'b0,
    OWNER_DM = 1'b1
  } arb_owner_e;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

  // Instruction fetches are always full-word reads.
  localparam logic [3:0] FETCH_BE = 4'b1111;

  // Memory request fields for a fetch of the given word address.
  function automatic mem_req_t fetch_req(input logic [31:0] addr);
    mem_req_t r;
    r.we    = 1'b0;
    r.be    = FETCH_BE;
    r.addr  = addr;
    r.wdata = 32'h0000_0000;
    return r;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter.sv
// Arbitrates one shared memory port between instruction fetch (IF) and
// load/store (DM). One transaction is in flight at a time; DM is favoured
// unless fetch has been passed over STARVE_LIMIT consecutive times.
//
// Ports:
//   clk_i, rst_i                 clock, async active-high reset
//   if_req_i/if_addr_i/if_flush_i fetch request, address, wrong-path flush
//   if_gnt_o/if_rvalid_o         fetch accept pulse, fetch response pulse
//   dm_req_i/we/be/addr/wdata    load/store request and fields
//   dm_gnt_o/dm_rvalid_o         data accept pulse, data response/ack pulse
//   rdata_o                      response data (mirrors mem_rdata_i)
//   mem_req_o/we/be/addr/wdata   registered memory request
//   mem_gnt_i                    memory accepts the request
//   mem_rvalid_i/mem_rdata_i     memory response
module mem_bus_arbiter
  import riscv_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  input  logic        if_flush_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  input  logic        dm_req_i,
  input  logic        dm_we_i,
  input  logic [3:0]  dm_be_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_wdata_i,
  output logic        dm_gnt_o,
  output logic        dm_rvalid_o,
  output logic [31:0] rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  localparam int              CNT_W   = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  arb_state_e       state_r;
  arb_state_e       state_s;
  arb_owner_e       owner_r;
  logic [CNT_W-1:0] starve_r;
  logic             flush_pend_r;
  mem_req_t         mem_q_r;
  logic             mem_req_r;
  logic             if_win_s;
  logic             dm_win_s;
  logic             rsp_fire_s;

  // Next-state and arbitration decision.
  always_comb begin
    state_s    = state_r;
    if_win_s   = 1'b0;
    dm_win_s   = 1'b0;
    rsp_fire_s = 1'b0;
    case (state_r)
      IDLE: begin
        // Fetch only beats a concurrent DM request once it has starved.
        if (if_req_i && (!dm_req_i || starve_r == LIMIT_C)) begin
          if_win_s = 1'b1;
          state_s  = REQ;
        end else if (dm_req_i) begin
          dm_win_s = 1'b1;
          state_s  = REQ;
        end else begin
          state_s  = IDLE;
        end
      end
      REQ: begin
        if (mem_gnt_i) begin
          state_s = RSP;
        end else begin
          state_s = REQ;
        end
      end
      RSP: begin
        if (mem_rvalid_i) begin
          rsp_fire_s = 1'b1;
          state_s    = IDLE;
        end else begin
          state_s    = RSP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // FSM, owner, starvation counter and registered memory request.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r      <= IDLE;
      owner_r      <= OWNER_IF;
      starve_r     <= '0;
      flush_pend_r <= 1'b0;
      mem_q_r      <= '0;
      mem_req_r    <= 1'b0;
    end else begin
      state_r <= state_s;
      if (if_win_s) begin
        owner_r      <= OWNER_IF;
        starve_r     <= '0;
        flush_pend_r <= 1'b0;
        mem_q_r      <= fetch_req(if_addr_i);
        mem_req_r    <= 1'b1;
      end else if (dm_win_s) begin
        owner_r      <= OWNER_DM;
        flush_pend_r <= 1'b0;
        mem_q_r      <= '{we: dm_we_i, be: dm_be_i, addr: dm_addr_i, wdata: dm_wdata_i};
        mem_req_r    <= 1'b1;
        // Count DM wins only while fetch is actually waiting; saturate.
        if (if_req_i && starve_r != LIMIT_C) begin
          starve_r <= starve_r + CNT_W'(1);
        end else begin
          starve_r <= starve_r;
        end
      end else begin
        // A flush while fetch owns the bus squashes its response later.
        if ((state_r == REQ || state_r == RSP) && owner_r == OWNER_IF && if_flush_i) begin
          flush_pend_r <= 1'b1;
        end else begin
          flush_pend_r <= flush_pend_r;
        end
        if (state_r == REQ && mem_gnt_i) begin
          mem_req_r <= 1'b0;
        end else begin
          mem_req_r <= mem_req_r;
        end
      end
    end
  end

  // Grants are combinational with the arbitration; forced low during reset.
  assign if_gnt_o    = if_win_s & ~rst_i;
  assign dm_gnt_o    = dm_win_s & ~rst_i;
  assign if_rvalid_o = rsp_fire_s & (owner_r == OWNER_IF) & ~flush_pend_r & ~if_flush_i;
  assign dm_rvalid_o = rsp_fire_s & (owner_r == OWNER_DM);
  assign rdata_o     = mem_rdata_i;

  assign mem_req_o   = mem_req_r;
  assign mem_we_o    = mem_q_r.we;
  assign mem_be_o    = mem_q_r.be;
  assign mem_addr_o  = mem_q_r.addr;
  assign mem_wdata_o = mem_q_r.wdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized scoreboard bench for mem_bus_arbiter.
module tb_mem_bus_arbiter;

  localparam int LIMIT = 4;

  typedef struct {
    int          cyc;
    logic [1:0]  who;   // {if, dm}
    logic [31:0] data;
  } ev_t;

  typedef struct {
    int          cyc;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mev_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_flush, if_gnt, if_rvalid;
  logic [31:0] if_addr;
  logic        dm_req, dm_we, dm_gnt, dm_rvalid;
  logic [3:0]  dm_be;
  logic [31:0] dm_addr, dm_wdata, rdata;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  mem_bus_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_flush_i(if_flush),
    .if_gnt_o(if_gnt), .if_rvalid_o(if_rvalid),
    .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_be_i(dm_be), .dm_addr_i(dm_addr),
    .dm_wdata_i(dm_wdata), .dm_gnt_o(dm_gnt), .dm_rvalid_o(dm_rvalid),
    .rdata_o(rdata),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  ev_t  gnt_q[$];
  ev_t  rsp_q[$];
  mev_t mem_q[$];

  // Stimulus knobs (percent).
  int if_rate, dm_rate, gnt_rate, rv_rate, flush_rate, spur_rate;

  // What happened in the cycle just completed, for the bus masters/memory.
  bit if_gnt_seen, dm_gnt_seen, acc_seen, rv_seen, mem_pend;

  // Reference model: one transaction at a time, simple phases.
  bit          m_busy, m_acc, m_is_if, m_squash;
  int          m_streak;
  logic        m_we;
  logic [3:0]  m_be;
  logic [31:0] m_addr, m_wdata;

  initial forever begin
    @(negedge clk);
    #1;
    cyc++;
    if (rst) begin
      m_busy = 0; m_acc = 0; m_squash = 0; m_streak = 0;
    end else if (!m_busy) begin
      if (if_req && (!dm_req || m_streak == LIMIT)) begin
        m_is_if = 1; m_streak = 0;
        m_we = 1'b0; m_be = 4'b1111; m_addr = if_addr; m_wdata = 32'h0;
        m_busy = 1;
      end else if (dm_req) begin
        m_is_if = 0;
        if (if_req && m_streak < LIMIT) m_streak++;
        m_we = dm_we; m_be = dm_be; m_addr = dm_addr; m_wdata = dm_wdata;
        m_busy = 1;
      end
      if (m_busy) begin
        gnt_q.push_back('{cyc: cyc, who: (m_is_if ? 2'b10 : 2'b01), data: 32'h0});
        m_acc = 0; m_squash = 0;
      end
    end else if (!m_acc) begin
      mem_q.push_back('{cyc: cyc, we: m_we, be: m_be, addr: m_addr, wdata: m_wdata});
      if (m_is_if && if_flush) m_squash = 1;
      if (mem_gnt) m_acc = 1;
    end else begin
      if (m_is_if && if_flush) m_squash = 1;
      if (mem_rvalid) begin
        if (!(m_is_if && m_squash))
          rsp_q.push_back('{cyc: cyc, who: (m_is_if ? 2'b10 : 2'b01), data: mem_rdata});
        m_busy = 0;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT shows an event or one is due.
  initial forever begin
    logic [1:0] dw, ew;
    bit         eh;
    @(negedge clk);
    #2;
    if (rst) begin
      vectors++;
      if ({if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_req, mem_we, mem_be, mem_addr, mem_wdata} != '0) begin
        miscompares++;
        $display("FAIL rst_outputs cyc=%0d gnt=%b%b rv=%b%b mem_req=%b we=%b be=%h addr=%h wdata=%h want all 0",
                 cyc, if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_req, mem_we, mem_be, mem_addr, mem_wdata);
      end
    end else begin
      dw = {if_gnt, dm_gnt};
      eh = gnt_q.size() > 0 && gnt_q[0].cyc == cyc;
      if (dw != 2'b00 || eh) begin
        vectors++;
        ew = eh ? gnt_q[0].who : 2'b00;
        if (dw !== ew) begin
          miscompares++;
          $display("FAIL gnt cyc=%0d got {if,dm}=%b want %b", cyc, dw, ew);
        end
        if (eh) void'(gnt_q.pop_front());
      end
      dw = {if_rvalid, dm_rvalid};
      eh = rsp_q.size() > 0 && rsp_q[0].cyc == cyc;
      if (dw != 2'b00 || eh) begin
        vectors++;
        ew = eh ? rsp_q[0].who : 2'b00;
        if (dw !== ew || (eh && rdata !== rsp_q[0].data)) begin
          miscompares++;
          $display("FAIL rsp cyc=%0d got {if,dm}=%b rdata=%h want %b rdata=%h",
                   cyc, dw, rdata, ew, eh ? rsp_q[0].data : 32'h0);
        end
        if (eh) void'(rsp_q.pop_front());
      end
      eh = mem_q.size() > 0 && mem_q[0].cyc == cyc;
      if (mem_req || eh) begin
        vectors++;
        if (!(mem_req && eh) || mem_we !== mem_q[0].we || mem_be !== mem_q[0].be ||
            mem_addr !== mem_q[0].addr || mem_wdata !== mem_q[0].wdata) begin
          miscompares++;
          if (eh)
            $display("FAIL mem cyc=%0d got req=%b we=%b be=%h addr=%h wdata=%h want req=1 we=%b be=%h addr=%h wdata=%h",
                     cyc, mem_req, mem_we, mem_be, mem_addr, mem_wdata,
                     mem_q[0].we, mem_q[0].be, mem_q[0].addr, mem_q[0].wdata);
          else
            $display("FAIL mem cyc=%0d got req=%b want req=0", cyc, mem_req);
        end
        if (eh) void'(mem_q.pop_front());
      end
    end
  end

  // Record handshakes of the cycle for the masters and the memory.
  initial forever begin
    @(negedge clk);
    #3;
    if_gnt_seen = if_gnt;
    dm_gnt_seen = dm_gnt;
    acc_seen    = mem_req && mem_gnt;
    rv_seen     = mem_rvalid;
  end

  // One clock of stimulus: masters hold requests until granted.
  task automatic step(input bit r);
    @(negedge clk);
    rst = r;
    if (rv_seen) mem_pend = 0;
    if (acc_seen) mem_pend = 1;
    if (!if_req || if_gnt_seen) begin
      if_req  = ($urandom_range(99) < if_rate);
      if_addr = $urandom & 32'hFFFF_FFFC;
    end
    if (!dm_req || dm_gnt_seen) begin
      dm_req   = ($urandom_range(99) < dm_rate);
      dm_we    = $urandom_range(1);
      dm_be    = 4'($urandom_range(15));
      dm_addr  = $urandom;
      dm_wdata = $urandom;
    end
    mem_gnt    = mem_req  ? ($urandom_range(99) < gnt_rate) : ($urandom_range(99) < spur_rate);
    mem_rvalid = mem_pend ? ($urandom_range(99) < rv_rate)  : ($urandom_range(99) < spur_rate);
    mem_rdata  = $urandom;
    if_flush   = ($urandom_range(99) < flush_rate);
  endtask

  task automatic knobs(input int i, input int d, input int g, input int v, input int f, input int s);
    if_rate = i; dm_rate = d; gnt_rate = g; rv_rate = v; flush_rate = f; spur_rate = s;
  endtask

  initial begin
    int waited;
    rst = 1'b1; if_req = 0; if_addr = 0; if_flush = 0;
    dm_req = 0; dm_we = 0; dm_be = 0; dm_addr = 0; dm_wdata = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    if_gnt_seen = 0; dm_gnt_seen = 0; acc_seen = 0; rv_seen = 0; mem_pend = 0;
    knobs(0, 0, 0, 0, 0, 0);
    repeat (3) step(1'b1);

    knobs(100, 0, 100, 100, 0, 0);     // fetch alone, fastest memory
    repeat (30) step(1'b0);
    knobs(100, 100, 100, 100, 0, 0);   // both always requesting: starvation
    repeat (60) step(1'b0);
    knobs(50, 50, 15, 40, 0, 0);       // slow memory acceptance
    repeat (150) step(1'b0);
    knobs(40, 40, 60, 60, 15, 20);     // flushes and stray handshakes
    repeat (1500) step(1'b0);

    // Reset while a transaction waits for its response.
    knobs(100, 0, 100, 0, 0, 0);
    waited = 0;
    while (!(m_busy && m_acc) && waited < 50) begin
      step(1'b0);
      waited++;
    end
    vectors++;
    if (!(m_busy && m_acc)) begin
      miscompares++;
      $display("FAIL reach_rsp waited=%0d cycles want a response phase within 50", waited);
    end
    knobs(0, 0, 100, 0, 0, 0);
    step(1'b1);
    step(1'b1);
    knobs(0, 0, 100, 100, 0, 0);       // late response after release
    repeat (10) step(1'b0);

    knobs(60, 60, 50, 50, 10, 10);
    repeat (500) step(1'b0);
    knobs(0, 0, 100, 100, 0, 0);       // drain
    repeat (30) step(1'b0);

    @(negedge clk);
    #4;
    vectors++;
    if (gnt_q.size() + rsp_q.size() + mem_q.size() != 0) begin
      miscompares++;
      $display("FAIL leftover got gnt=%0d rsp=%0d mem=%0d pending want 0",
               gnt_q.size(), rsp_q.size(), mem_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
